// File: rtl/riscv_core_cache_mem_arbiter.sv
// riscv_core_cache_mem_arbiter: round-robin owner of the shared AXI memory
// port, steering block requests from the icache and dcache controllers.
module riscv_core_cache_mem_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_ic_mem_req,
    input  logic [ADDR_WIDTH-1:0]     i_ic_addr,
    output logic                      o_ic_mem_done,
    input  logic                      i_dc_mem_req,
    input  logic                      i_dc_we,
    input  logic [ADDR_WIDTH-1:0]     i_dc_addr,
    input  logic [AXI_DATA_WIDTH-1:0] i_dc_wdata,
    output logic                      o_dc_mem_done,
    output logic [AXI_DATA_WIDTH-1:0] o_rdata,
    output logic                      o_axi_req,
    output logic                      o_axi_we,
    output logic [ADDR_WIDTH-1:0]     o_axi_addr,
    output logic [AXI_DATA_WIDTH-1:0] o_axi_wdata,
    input  logic                      i_axi_done,
    input  logic [AXI_DATA_WIDTH-1:0] i_axi_rdata,
    output logic                      o_busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT_IC = 2'b01,
        GRANT_DC = 2'b10
    } state_t;

    typedef enum logic {
        PTR_IC = 1'b0,
        PTR_DC = 1'b1
    } ptr_t;

    state_t r_state;
    state_t w_state_nxt;
    ptr_t   r_rr_ptr;
    ptr_t   w_rr_ptr_nxt;

    logic                      w_pick_dc;
    logic                      w_axi_req;
    logic                      w_axi_we;
    logic [ADDR_WIDTH-1:0]     w_axi_addr;
    logic [AXI_DATA_WIDTH-1:0] w_axi_wdata;
    logic                      w_ic_done;
    logic                      w_dc_done;
    logic                      w_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_rr_ptr <= PTR_IC;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Dcache wins when it is the only requester or holds the priority.
    assign w_pick_dc = i_dc_mem_req
                     & (~i_ic_mem_req | (r_rr_ptr == PTR_DC));

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_axi_req    = 1'b0;
        w_axi_we     = 1'b0;
        w_axi_addr   = '0;
        w_axi_wdata  = '0;
        w_ic_done    = 1'b0;
        w_dc_done    = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_ic_mem_req | i_dc_mem_req) begin
                    w_state_nxt = w_pick_dc ? GRANT_DC : GRANT_IC;
                end
            end
            GRANT_IC: begin
                w_busy     = 1'b1;
                w_axi_req  = ~i_axi_done;
                w_axi_addr = i_ic_addr;
                w_ic_done  = i_axi_done;
                if (i_axi_done) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = PTR_DC;
                end
            end
            GRANT_DC: begin
                w_busy      = 1'b1;
                w_axi_req   = ~i_axi_done;
                w_axi_we    = i_dc_we;
                w_axi_addr  = i_dc_addr;
                w_axi_wdata = i_dc_wdata;
                w_dc_done   = i_axi_done;
                if (i_axi_done) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = PTR_IC;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Everything is forced quiet while reset is held.
    assign o_axi_req     = i_rst_n & w_axi_req;
    assign o_axi_we      = i_rst_n & w_axi_we;
    assign o_axi_addr    = i_rst_n ? w_axi_addr  : '0;
    assign o_axi_wdata   = i_rst_n ? w_axi_wdata : '0;
    assign o_ic_mem_done = i_rst_n & w_ic_done;
    assign o_dc_mem_done = i_rst_n & w_dc_done;
    assign o_busy        = i_rst_n & w_busy;
    assign o_rdata       = i_rst_n ? i_axi_rdata : '0;

endmodule

// File: tb/tb_riscv_core_cache_mem_arbiter.sv
// tb_riscv_core_cache_mem_arbiter: directed and randomized checks of the
// cache memory-port arbiter against a queue-based round-robin model.
module tb_riscv_core_cache_mem_arbiter;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_ic_mem_req;
    logic [63:0]  i_ic_addr;
    logic         o_ic_mem_done;
    logic         i_dc_mem_req;
    logic         i_dc_we;
    logic [63:0]  i_dc_addr;
    logic [255:0] i_dc_wdata;
    logic         o_dc_mem_done;
    logic [255:0] o_rdata;
    logic         o_axi_req;
    logic         o_axi_we;
    logic [63:0]  o_axi_addr;
    logic [255:0] o_axi_wdata;
    logic         i_axi_done;
    logic [255:0] i_axi_rdata;
    logic         o_busy;

    riscv_core_cache_mem_arbiter #(
        .ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(256)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_ic_mem_req(i_ic_mem_req),
        .i_ic_addr(i_ic_addr),
        .o_ic_mem_done(o_ic_mem_done),
        .i_dc_mem_req(i_dc_mem_req),
        .i_dc_we(i_dc_we),
        .i_dc_addr(i_dc_addr),
        .i_dc_wdata(i_dc_wdata),
        .o_dc_mem_done(o_dc_mem_done),
        .o_rdata(o_rdata),
        .o_axi_req(o_axi_req),
        .o_axi_we(o_axi_we),
        .o_axi_addr(o_axi_addr),
        .o_axi_wdata(o_axi_wdata),
        .i_axi_done(i_axi_done),
        .i_axi_rdata(i_axi_rdata),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit           side;
        logic         we;
        logic [63:0]  addr;
        logic [255:0] wdata;
    } txn_t;

    txn_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 0;
    bit   mptr    = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chka(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [255:0] act,
                        input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd_blk();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [63:0] rnd_addr();
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[4:0] = 5'd0;
        return a;
    endfunction

    task automatic drv();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: pops the expected owner at every new grant and checks
    // the steering of done/rdata when the transaction completes.
    initial begin
        txn_t cur;
        bit   have_cur;
        logic prev_req;
        have_cur = 0;
        prev_req = 0;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                if (o_axi_req && !prev_req) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_extra_grant: got addr %h expected none",
                                 o_axi_addr);
                    end else begin
                        cur = sb.pop_front();
                        have_cur = 1;
                        chka("sb_addr", o_axi_addr, cur.addr);
                        chk1("sb_we", o_axi_we, cur.we);
                        chkw("sb_wdata", o_axi_wdata, cur.wdata);
                        chk1("sb_busy", o_busy, 1'b1);
                    end
                end else if (have_cur && !i_axi_done) begin
                    chk1("sb_hold_req", o_axi_req, 1'b1);
                    chk1("sb_ic_done_idle", o_ic_mem_done, 1'b0);
                    chk1("sb_dc_done_idle", o_dc_mem_done, 1'b0);
                end
                if (i_axi_done && have_cur) begin
                    chk1("sb_ic_done", o_ic_mem_done, logic'(!cur.side));
                    chk1("sb_dc_done", o_dc_mem_done, logic'(cur.side));
                    chk1("sb_req_drop", o_axi_req, 1'b0);
                    chkw("sb_rdata", o_rdata, i_axi_rdata);
                    have_cur = 0;
                end
            end
            prev_req = o_axi_req;
        end
    end

    // Both clients hold their queues of requests; expected grant order
    // is alternation starting from the priority side, then the leftover.
    task automatic run_burst(input int nic, input int ndc);
        txn_t icq[$];
        txn_t dcq[$];
        txn_t t;
        int   i;
        int   j;
        int   cyc;
        int   resp_cnt;
        logic ics;
        logic dcs;
        logic reqs;
        for (int k = 0; k < nic; k++) begin
            t.side = 0;
            t.we = 1'b0;
            t.addr = rnd_addr();
            t.wdata = '0;
            icq.push_back(t);
        end
        for (int k = 0; k < ndc; k++) begin
            t.side = 1;
            t.we = 1'($urandom_range(0, 1));
            t.addr = rnd_addr();
            t.wdata = rnd_blk();
            dcq.push_back(t);
        end
        i = 0;
        j = 0;
        while (i < nic || j < ndc) begin
            if (i < nic && (j >= ndc || mptr == 0)) begin
                sb.push_back(icq[i]);
                i++;
                mptr = 1;
            end else begin
                sb.push_back(dcq[j]);
                j++;
                mptr = 0;
            end
        end
        mon_en = 1;
        resp_cnt = -1;
        cyc = 0;
        i_ic_mem_req = icq.size() > 0;
        i_ic_addr = (icq.size() > 0) ? icq[0].addr : '0;
        i_dc_mem_req = dcq.size() > 0;
        i_dc_we = (dcq.size() > 0) ? dcq[0].we : 1'b0;
        i_dc_addr = (dcq.size() > 0) ? dcq[0].addr : '0;
        i_dc_wdata = (dcq.size() > 0) ? dcq[0].wdata : '0;
        while ((icq.size() > 0 || dcq.size() > 0) && cyc < 600) begin
            @(negedge i_clk);
            ics = o_ic_mem_done;
            dcs = o_dc_mem_done;
            reqs = o_axi_req;
            drv();
            cyc++;
            if (i_axi_done) begin
                i_axi_done = 1'b0;
            end else if (reqs) begin
                if (resp_cnt < 0) resp_cnt = $urandom_range(0, 3);
                if (resp_cnt == 0) begin
                    i_axi_done = 1'b1;
                    i_axi_rdata = rnd_blk();
                    resp_cnt = -1;
                end else begin
                    resp_cnt--;
                end
            end
            if (ics && icq.size() > 0) void'(icq.pop_front());
            if (dcs && dcq.size() > 0) void'(dcq.pop_front());
            i_ic_mem_req = icq.size() > 0;
            i_ic_addr = (icq.size() > 0) ? icq[0].addr : '0;
            i_dc_mem_req = dcq.size() > 0;
            i_dc_we = (dcq.size() > 0) ? dcq[0].we : 1'b0;
            i_dc_addr = (dcq.size() > 0) ? dcq[0].addr : '0;
            i_dc_wdata = (dcq.size() > 0) ? dcq[0].wdata : '0;
        end
        i_axi_done = 1'b0;
        i_ic_mem_req = 1'b0;
        i_dc_mem_req = 1'b0;
        n_tests++;
        if (cyc >= 600 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL burst_drain: got %0d cycles, %0d left expected 0 left",
                     cyc, sb.size());
        end
        sb.delete();
        drv();
        mon_en = 0;
        drv();
    endtask

    initial begin
        logic [255:0] wd;
        i_rst_n = 1'b0;
        i_ic_mem_req = 1'b1;
        i_ic_addr = 64'h1000;
        i_dc_mem_req = 1'b1;
        i_dc_we = 1'b1;
        i_dc_addr = 64'h2000;
        i_dc_wdata = rnd_blk();
        i_axi_done = 1'b1;
        i_axi_rdata = {8{32'hdeadbeef}};
        repeat (2) @(negedge i_clk);
        chk1("rst_axi_req", o_axi_req, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_ic_done", o_ic_mem_done, 1'b0);
        chk1("rst_dc_done", o_dc_mem_done, 1'b0);
        chk1("rst_we", o_axi_we, 1'b0);
        chka("rst_addr", o_axi_addr, 64'h0);
        chkw("rst_wdata", o_axi_wdata, 256'h0);
        chkw("rst_rdata", o_rdata, 256'h0);
        i_ic_mem_req = 1'b0;
        i_dc_mem_req = 1'b0;
        i_axi_done = 1'b0;
        i_axi_rdata = '0;
        drv();
        i_rst_n = 1'b1;

        // Single icache refill with fixed latency.
        drv();
        i_ic_mem_req = 1'b1;
        i_ic_addr = 64'h1000;
        @(negedge i_clk);
        chk1("t1_c0_req", o_axi_req, 1'b0);
        drv();
        @(negedge i_clk);
        chk1("t1_c1_req", o_axi_req, 1'b1);
        chka("t1_c1_addr", o_axi_addr, 64'h1000);
        chk1("t1_c1_we", o_axi_we, 1'b0);
        chkw("t1_c1_wdata", o_axi_wdata, 256'h0);
        chk1("t1_c1_busy", o_busy, 1'b1);
        repeat (3) drv();
        drv();
        i_axi_done = 1'b1;
        i_axi_rdata = {32{8'hA5}};
        @(negedge i_clk);
        chk1("t1_c5_ic_done", o_ic_mem_done, 1'b1);
        chk1("t1_c5_dc_done", o_dc_mem_done, 1'b0);
        chk1("t1_c5_req", o_axi_req, 1'b0);
        chkw("t1_c5_rdata", o_rdata, {32{8'hA5}});
        drv();
        i_axi_done = 1'b0;
        i_ic_mem_req = 1'b0;
        @(negedge i_clk);
        chk1("t1_c6_busy", o_busy, 1'b0);
        chk1("t1_c6_ic_done", o_ic_mem_done, 1'b0);

        // Async reset in the middle of a dcache write-back grant.
        drv();
        wd = rnd_blk();
        i_dc_mem_req = 1'b1;
        i_dc_we = 1'b1;
        i_dc_addr = 64'h2000;
        i_dc_wdata = wd;
        drv();
        @(negedge i_clk);
        chk1("rp_dc_req", o_axi_req, 1'b1);
        chk1("rp_dc_we", o_axi_we, 1'b1);
        chka("rp_dc_addr", o_axi_addr, 64'h2000);
        chkw("rp_dc_wdata", o_axi_wdata, wd);
        i_ic_mem_req = 1'b1;
        i_ic_addr = 64'h4000;
        #2 i_rst_n = 1'b0;
        #1;
        chk1("rp_async_req", o_axi_req, 1'b0);
        chk1("rp_async_busy", o_busy, 1'b0);
        drv();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk1("rp_idle_req", o_axi_req, 1'b0);
        drv();
        @(negedge i_clk);
        chk1("rp_ic_first_req", o_axi_req, 1'b1);
        chka("rp_ic_first_addr", o_axi_addr, 64'h4000);
        chk1("rp_ic_first_we", o_axi_we, 1'b0);
        i_ic_mem_req = 1'b0;
        i_dc_mem_req = 1'b0;
        i_rst_n = 1'b0;
        drv();
        i_rst_n = 1'b1;
        mptr = 0;

        // Randomized bursts; first one starts from the reset priority.
        run_burst(3, 2);
        for (int b = 0; b < 8; b++) begin
            run_burst(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end
        run_burst(4, 4);

        // Spurious done while idle, then icache drops req mid-grant.
        drv();
        i_axi_done = 1'b1;
        i_axi_rdata = rnd_blk();
        @(negedge i_clk);
        chk1("sp_ic_done", o_ic_mem_done, 1'b0);
        chk1("sp_dc_done", o_dc_mem_done, 1'b0);
        chk1("sp_busy", o_busy, 1'b0);
        drv();
        i_axi_done = 1'b0;
        i_ic_mem_req = 1'b1;
        i_ic_addr = 64'h5000;
        @(negedge i_clk);
        chk1("sp_next_busy", o_busy, 1'b0);
        drv();
        @(negedge i_clk);
        chk1("dr_grant_req", o_axi_req, 1'b1);
        drv();
        i_ic_mem_req = 1'b0;
        @(negedge i_clk);
        chk1("dr_hold_req", o_axi_req, 1'b1);
        chk1("dr_hold_busy", o_busy, 1'b1);
        drv();
        @(negedge i_clk);
        chk1("dr_hold_req2", o_axi_req, 1'b1);
        drv();
        i_axi_done = 1'b1;
        @(negedge i_clk);
        chk1("dr_ic_done", o_ic_mem_done, 1'b1);
        chk1("dr_req_drop", o_axi_req, 1'b0);
        drv();
        i_axi_done = 1'b0;
        @(negedge i_clk);
        chk1("dr_idle_busy", o_busy, 1'b0);

        // Continuous dcache requester: re-grant two cycles after done.
        drv();
        i_dc_mem_req = 1'b1;
        i_dc_we = 1'b0;
        i_dc_addr = 64'h3000;
        @(negedge i_clk);
        chk1("gp_c0_req", o_axi_req, 1'b0);
        drv();
        @(negedge i_clk);
        chk1("gp_c1_req", o_axi_req, 1'b1);
        drv();
        i_axi_done = 1'b1;
        @(negedge i_clk);
        chk1("gp_c2_dc_done", o_dc_mem_done, 1'b1);
        chk1("gp_c2_ic_done", o_ic_mem_done, 1'b0);
        drv();
        i_axi_done = 1'b0;
        i_dc_addr = 64'h3020;
        @(negedge i_clk);
        chk1("gp_c3_req", o_axi_req, 1'b0);
        drv();
        @(negedge i_clk);
        chk1("gp_c4_req", o_axi_req, 1'b1);
        chka("gp_c4_addr", o_axi_addr, 64'h3020);
        drv();
        i_axi_done = 1'b1;
        @(negedge i_clk);
        chk1("gp_c5_dc_done", o_dc_mem_done, 1'b1);
        drv();
        i_axi_done = 1'b0;
        i_dc_mem_req = 1'b0;
        @(negedge i_clk);
        chk1("gp_c6_busy", o_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
